// File: rtl/block_words.sv
// rtl/block_words.sv - serialises WORD_W*WORDS-bit blocks into WORD_W-bit words, word 0 from the MSBs
// Optional BLOCK_WORDS_LAST_EN adds a registered word_last flag on the final word of each block.
module block_words #(
    parameter int WORD_W = 32,
    parameter int WORDS  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      block_valid,
    output logic                      block_ready,
    input  logic [WORD_W*WORDS-1:0]   block,
    output logic                      word_valid,
    input  logic                      word_ready,
`ifdef BLOCK_WORDS_LAST_EN
    output logic                      word_last,
`endif
    output logic [WORD_W-1:0]         word
);

    localparam int BLK_W = WORD_W * WORDS;
    localparam int CW    = $clog2(WORDS + 1);

    logic [BLK_W-1:0] sr;
    logic [BLK_W-1:0] sr_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             load;
    logic             shift;

    // A new block may only enter when the register is empty or its last word leaves this cycle.
    assign block_ready = !rst && ((cnt == '0) || ((cnt == CW'(1)) && word_ready));
    assign word_valid  = (cnt != '0);
    assign word        = sr[BLK_W-1 -: WORD_W];

    assign load  = block_valid && block_ready;
    assign shift = word_valid && word_ready && !load;

    always_comb begin
        sr_nxt  = sr;
        cnt_nxt = cnt;
        if (load) begin
            sr_nxt  = block;
            cnt_nxt = CW'(WORDS);
        end else if (shift) begin
            sr_nxt  = sr << WORD_W;
            cnt_nxt = cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else begin
            sr  <= sr_nxt;
            cnt <= cnt_nxt;
        end
    end

`ifdef BLOCK_WORDS_LAST_EN
    // Tracks cnt==1 from the next-state value so the flag is a plain register output.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_last <= 1'b0;
        end else begin
            word_last <= (cnt_nxt == CW'(1));
        end
    end
`endif

endmodule

// File: tb/tb_block_words.sv
// tb/tb_block_words.sv - scoreboard bench for block_words; word_last checked when BLOCK_WORDS_LAST_EN is set
module tb_block_words;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         block_valid = 1'b0;
    logic         block_ready;
    logic [127:0] block = '0;
    logic         word_valid;
    logic         word_ready = 1'b0;
    logic [31:0]  word;
`ifdef BLOCK_WORDS_LAST_EN
    logic         word_last;
`endif

    block_words #(.WORD_W(32), .WORDS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .block       (block),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
`ifdef BLOCK_WORDS_LAST_EN
        .word_last   (word_last),
`endif
        .word        (word)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard entries: {last_flag, word}
    logic [32:0] sb[$];
    int          cyc = 0;
    int          n_cons = 0;
    int          cons_cyc[256];
    logic        br_at_last = 1'b0;
    logic        hold_prev = 1'b0;
    logic [31:0] prev_word = '0;

    always @(negedge clk) begin
        logic [32:0] e;
        cyc++;
        if (rst) begin
            chk("rst_block_ready", block_ready, 1'b0);
            sb.delete();
            hold_prev <= 1'b0;
        end else begin
            if (hold_prev)
                chk("hold_stable", word, prev_word);
            if (word_valid && word_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", word, 33'h0);
                end else begin
                    e = sb.pop_front();
                    chk("word", word, e[31:0]);
`ifdef BLOCK_WORDS_LAST_EN
                    chk("word_last", word_last, e[32]);
`endif
                    if (e[32]) br_at_last <= block_ready;
                end
                if (n_cons < 256) cons_cyc[n_cons] <= cyc;
                n_cons++;
            end
`ifdef BLOCK_WORDS_LAST_EN
            else if (word_valid) begin
                chk("word_last_idle", word_last, (sb.size() == 1) ? 1'b1 : 1'b0);
            end
`endif
            if (block_valid && block_ready) begin
                for (int i = 0; i < 4; i++)
                    sb.push_back({(i == 3), block[127 - 32*i -: 32]});
            end
            hold_prev <= word_valid && !word_ready;
            prev_word <= word;
        end
    end

    task automatic put_block(input logic [127:0] b);
        bit done = 0;
        block       = b;
        block_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (block_ready) begin
                @(posedge clk);
                #1;
                block_valid = 1'b0;
                done = 1;
            end
        end
        if (!done) begin
            chk("put_block_timeout", 1'b0, 1'b1);
            block_valid = 1'b0;
        end
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            #1;
            if (!word_valid) done = 1;
        end
        if (!done) chk("drain_timeout", 1'b0, 1'b1);
    endtask

    logic [127:0] blk_a = 128'h0123456789ABCDEFA0A0A0A0F9F9F9F9;
    logic [127:0] blk_b = 128'h76543210FEDCBA98B1B1B1B1E8E8E8E8;
    logic [127:0] blk_c = 128'hFEDCBA9876543210B1B1B1B1E8E8E8E8;
    bit           toggling = 0;
    int           c0;

    initial begin
        // 1 reset
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("reset_word_valid", word_valid, 1'b0);
            chk("reset_block_ready", block_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_reset_block_ready", block_ready, 1'b1);
        chk("post_reset_word_valid", word_valid, 1'b0);
        chk("post_reset_word", word, 32'h0);

        // 2 max throughput, back-to-back blocks
        word_ready = 1'b1;
        c0 = n_cons;
        put_block(blk_a);
        chk("latency_word0_valid", word_valid, 1'b1);
        chk("latency_word0", word, 32'h01234567);
        put_block(blk_b);
        drain();
        chk("throughput_count", n_cons - c0, 8);
        chk("throughput_gapless", cons_cyc[c0 + 7] - cons_cyc[c0], 7);
        chk("block_ready_at_last", br_at_last, 1'b1);

        // 3 backpressure after the first word
        put_block(blk_a);
        @(posedge clk);
        #1;
        word_ready  = 1'b0;
        block       = blk_b;
        block_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_word", word, 32'h89ABCDEF);
            chk("bp_valid", word_valid, 1'b1);
            chk("bp_block_ready", block_ready, 1'b0);
        end
        block_valid = 1'b0;
        word_ready  = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_resume", word, 32'hA0A0A0A0);
        drain();

        // 4 sparse input with toggling word_ready
        c0 = n_cons;
        toggling = 1;
        fork
            begin
                while (toggling) begin
                    @(posedge clk);
                    #1;
                    word_ready = ~word_ready;
                end
            end
            begin
                put_block(blk_b);
                drain();
                toggling = 0;
            end
        join
        word_ready = 1'b1;
        chk("sparse_count", n_cons - c0, 4);
        chk("sparse_idle_valid", word_valid, 1'b0);
        chk("sparse_idle_ready", block_ready, 1'b1);
        repeat (3) @(negedge clk);
        chk("idle_valid", word_valid, 1'b0);

        // 5 mid-block reset
        put_block(blk_a);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_valid", word_valid, 1'b0);
        rst = 1'b0;
        put_block(blk_c);
        chk("midrst_first_word", word, 32'hFEDCBA98);
        drain();

        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
